// File: rtl/custom7_code_sequencer.sv
// custom7_code_sequencer: debounced up/down buttons drive a wrapping 3-bit code on c2..c0 with step/wrap pulses.
// Optional auto-advance prescaler and auto port when CUSTOM7_AUTO_RUN_EN is defined.
module custom7_code_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_CODE        = 7,
   parameter int TICK_DIV        = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_dn,
   input  logic hold,
`ifdef CUSTOM7_AUTO_RUN_EN
   input  logic auto,
`endif
   output logic c0,
   output logic c1,
   output logic c2,
   output logic step,
   output logic wrap
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [2:0] MAXC = 3'(MAX_CODE);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;
   logic [1:0] w_btn;
   logic [1:0] w_press;
   logic       w_tick;
   logic       w_go_up;
   logic       w_go_dn;
   logic [2:0] r_code;
   logic       r_step;
   logic       r_wrap;
   if (DEBOUNCE_CYCLES < 2 || MAX_CODE < 1 || MAX_CODE > 7 || TICK_DIV < 2) begin : g_bad_params
      $error("custom7_code_sequencer: illegal parameter value");
   end
   assign w_btn = {btn_dn, btn_up};
   // index 0 is the up button, index 1 the down button
   for (genvar g = 0; g < 2; g++) begin : g_db
      logic          r_s1;
      logic          r_s2;
      logic          r_press;
      db_state_t     r_st;
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_press <= 1'b0;
            r_st    <= IDLE;
            r_cnt   <= '0;
         end else begin
            r_s1    <= w_btn[g];
            r_s2    <= r_s1;
            r_press <= 1'b0;
            case (r_st)
               IDLE: if (r_s2) begin
                  r_st  <= PRESS_WAIT;
                  r_cnt <= CW'(1);
               end
               PRESS_WAIT: if (!r_s2) r_st <= IDLE;
                  else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                     r_st    <= PRESSED;
                     r_press <= 1'b1;
                  end else r_cnt <= r_cnt + CW'(1);
               PRESSED: if (!r_s2) begin
                  r_st  <= RELEASE_WAIT;
                  r_cnt <= CW'(1);
               end
               RELEASE_WAIT: if (r_s2) r_st <= PRESSED;
                  else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) r_st <= IDLE;
                  else r_cnt <= r_cnt + CW'(1);
            endcase
         end
      end
      assign w_press[g] = r_press;
   end
`ifdef CUSTOM7_AUTO_RUN_EN
   localparam int PW = $clog2(TICK_DIV);
   logic [PW-1:0] r_pre;
   assign w_tick = auto && !hold && r_pre == PW'(TICK_DIV - 1);
   always_ff @(posedge clk)
      r_pre <= (rst || !auto || hold || w_tick) ? '0 : r_pre + PW'(1);
`else
   assign w_tick = 1'b0;
`endif
   // simultaneous button pulses cancel, and any button pulse pre-empts an auto tick
   assign w_go_up = !hold && !w_press[1] && (w_press[0] || w_tick);
   assign w_go_dn = !hold && w_press[1] && !w_press[0];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_code <= 3'd0;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_step <= w_go_up || w_go_dn;
         r_wrap <= (w_go_up && r_code == MAXC) || (w_go_dn && r_code == 3'd0);
         if (w_go_up) r_code <= (r_code == MAXC) ? 3'd0 : r_code + 3'd1;
         else if (w_go_dn) r_code <= (r_code == 3'd0) ? MAXC : r_code - 3'd1;
      end
   end
   assign {c2, c1, c0} = r_code;
   assign step = r_step;
   assign wrap = r_wrap;
endmodule

// File: tb/tb_custom7_code_sequencer.sv
// tb_custom7_code_sequencer: directed and randomized checks of the code sequencer (MAX_CODE 7 and 5 instances).
// Define CUSTOM7_AUTO_RUN_EN to also exercise the auto-advance feature.
module tb_custom7_code_sequencer;
   localparam int D = 4;
   localparam int T = 10;
   logic clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_dn = 1'b0, hold = 1'b0;
`ifdef CUSTOM7_AUTO_RUN_EN
   logic auto = 1'b0;
`endif
   logic a_c0, a_c1, a_c2, a_step, a_wrap;
   logic b_c0, b_c1, b_c2, b_step, b_wrap;
   logic [2:0] a_code, b_code;
   int errors = 0, checks = 0;
   assign a_code = {a_c2, a_c1, a_c0};
   assign b_code = {b_c2, b_c1, b_c0};
   always #5 clk = ~clk;

   custom7_code_sequencer #(.DEBOUNCE_CYCLES(D), .MAX_CODE(7), .TICK_DIV(T)) dut_a (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .hold(hold),
`ifdef CUSTOM7_AUTO_RUN_EN
      .auto(auto),
`endif
      .c0(a_c0), .c1(a_c1), .c2(a_c2), .step(a_step), .wrap(a_wrap));

   custom7_code_sequencer #(.DEBOUNCE_CYCLES(D), .MAX_CODE(5), .TICK_DIV(T)) dut_b (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .hold(hold),
`ifdef CUSTOM7_AUTO_RUN_EN
      .auto(auto),
`endif
      .c0(b_c0), .c1(b_c1), .c2(b_c2), .step(b_step), .wrap(b_wrap));

   // Reference model: a button level is accepted once the synchronised input has shown the
   // opposite level for D consecutive samples; an accepted rise yields a press one cycle later.
   int m_code[2], m_run[2], m_pre;
   bit m_step[2], m_wrap[2], m_lvl[2], m_s1[2], m_s2[2], m_pp[2];
   always @(posedge clk) begin : model
      bit tick, up, dn;
      int mx;
      if (rst) begin
         m_pre = 0;
         for (int i = 0; i < 2; i++) begin
            m_code[i] = 0; m_step[i] = 0; m_wrap[i] = 0; m_lvl[i] = 0;
            m_s1[i] = 0; m_s2[i] = 0; m_pp[i] = 0; m_run[i] = 0;
         end
      end else begin
         tick = 0;
`ifdef CUSTOM7_AUTO_RUN_EN
         tick = auto && !hold && m_pre == T - 1;
         m_pre = (!auto || hold) ? 0 : (m_pre + 1) % T;
`endif
         up = !hold && !(m_pp[0] && m_pp[1]) && (m_pp[0] || (tick && !m_pp[1]));
         dn = !hold && m_pp[1] && !m_pp[0];
         for (int i = 0; i < 2; i++) begin
            mx = (i == 0) ? 7 : 5;
            m_step[i] = up || dn;
            m_wrap[i] = 0;
            if (up) begin
               m_wrap[i] = (m_code[i] == mx);
               m_code[i] = (m_code[i] + 1) % (mx + 1);
            end else if (dn) begin
               m_wrap[i] = (m_code[i] == 0);
               m_code[i] = (m_code[i] + mx) % (mx + 1);
            end
         end
         for (int j = 0; j < 2; j++) begin
            m_pp[j] = 0;
            if (m_s2[j] != m_lvl[j]) begin
               m_run[j]++;
               if (m_run[j] == D) begin
                  m_lvl[j] = m_s2[j];
                  m_run[j] = 0;
                  m_pp[j] = m_s2[j];
               end
            end else m_run[j] = 0;
            m_s2[j] = m_s1[j];
            m_s1[j] = (j == 0) ? btn_up : btn_dn;
         end
      end
   end

   task test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_code, a_step, a_wrap, b_code, b_step, b_wrap} !== 10'b0) begin
         errors++;
         $display("FAIL reset got=%b/%b/%b %b/%b/%b exp=000/0/0", a_code, a_step, a_wrap, b_code, b_step, b_wrap);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if ({a_code, a_step, a_wrap, b_code, b_step, b_wrap} !== 10'b0) begin
            errors++;
            $display("FAIL idle_after_reset cyc=%0d got=%b/%b/%b exp=000/0/0", k, a_code, a_step, a_wrap);
         end
      end
   endtask

   task test_latency;
      btn_up = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (a_code !== 3'(k >= D + 3) || a_step !== (k == D + 3) || a_wrap !== 1'b0 || b_code !== 3'(k >= D + 3)) begin
            errors++;
            $display("FAIL latency edge=%0d got code=%0d step=%b wrap=%b exp code=%0d step=%b wrap=0",
                     k, a_code, a_step, a_wrap, k >= D + 3, k == D + 3);
         end
      end
      btn_up = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task test_bounce;
      int press_steps, rel_steps;
      press_steps = 0;
      rel_steps = 0;
      for (int k = 0; k < 12; k++) begin
         btn_up = ((k / 2) % 2 == 0);
         @(negedge clk);
         press_steps += int'(a_step);
      end
      btn_up = 1'b1;
      repeat (12) begin @(negedge clk); press_steps += int'(a_step); end
      for (int r = 0; r < 4; r++) begin
         btn_up = 1'b0;
         repeat (3) begin @(negedge clk); rel_steps += int'(a_step); end
         btn_up = 1'b1;
         @(negedge clk); rel_steps += int'(a_step);
      end
      btn_up = 1'b0;
      repeat (12) begin @(negedge clk); rel_steps += int'(a_step); end
      checks++;
      if (press_steps !== 1) begin
         errors++;
         $display("FAIL bounce_press_steps got=%0d exp=1", press_steps);
      end
      checks++;
      if (rel_steps !== 0) begin
         errors++;
         $display("FAIL bounce_release_steps got=%0d exp=0", rel_steps);
      end
      checks++;
      if (a_code !== 3'd2 || b_code !== 3'd2) begin
         errors++;
         $display("FAIL bounce_code got=%0d/%0d exp=2/2", a_code, b_code);
      end
   endtask

   task test_wrap;
      int s7, w7, w7_at, w5, w5_at;
      s7 = 0; w7 = 0; w7_at = 0; w5 = 0; w5_at = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         for (int k = 0; k < 16; k++) begin
            btn_up = (k < 8);
            @(negedge clk);
            s7 += int'(a_step);
            if (a_wrap) begin w7++; w7_at = n; end
            if (b_wrap) begin w5++; w5_at = n; end
         end
         checks++;
         if (a_code !== 3'(n % 8) || b_code !== 3'(n % 6)) begin
            errors++;
            $display("FAIL wrap_up press=%0d got=%0d/%0d exp=%0d/%0d", n, a_code, b_code, n % 8, n % 6);
         end
      end
      checks++;
      if (s7 !== 8 || w7 !== 1 || w7_at !== 8) begin
         errors++;
         $display("FAIL wrap_up_max7 got steps=%0d wraps=%0d at=%0d exp steps=8 wraps=1 at=8", s7, w7, w7_at);
      end
      checks++;
      if (w5 !== 1 || w5_at !== 6) begin
         errors++;
         $display("FAIL wrap_up_max5 got wraps=%0d at=%0d exp wraps=1 at=6", w5, w5_at);
      end
      w7 = 0; w5 = 0;
      for (int k = 0; k < 16; k++) begin
         btn_dn = (k < 8);
         @(negedge clk);
         w7 += int'(a_wrap);
         w5 += int'(b_wrap);
      end
      checks++;
      if (a_code !== 3'd7 || b_code !== 3'd1 || w7 !== 1 || w5 !== 0) begin
         errors++;
         $display("FAIL wrap_dn got=%0d/%0d wraps=%0d/%0d exp=7/1 wraps=1/0", a_code, b_code, w7, w5);
      end
   endtask

   task test_both_hold;
      int s;
      s = 0;
      for (int k = 0; k < 16; k++) begin
         btn_up = (k < 8);
         btn_dn = (k < 8);
         @(negedge clk);
         s += int'(a_step) + int'(b_step);
      end
      checks++;
      if (s !== 0 || a_code !== 3'd7 || b_code !== 3'd1) begin
         errors++;
         $display("FAIL both_buttons got steps=%0d code=%0d/%0d exp steps=0 code=7/1", s, a_code, b_code);
      end
      hold = 1'b1;
      for (int k = 0; k < 16; k++) begin
         btn_up = (k < 8);
         @(negedge clk);
         s += int'(a_step) + int'(b_step);
      end
      hold = 1'b0;
      repeat (10) begin @(negedge clk); s += int'(a_step) + int'(b_step); end
      checks++;
      if (s !== 0 || a_code !== 3'd7 || b_code !== 3'd1) begin
         errors++;
         $display("FAIL hold_drop got steps=%0d code=%0d/%0d exp steps=0 code=7/1", s, a_code, b_code);
      end
      for (int k = 0; k < 16; k++) begin
         btn_up = (k < 8);
         @(negedge clk);
      end
      checks++;
      if (a_code !== 3'd0 || b_code !== 3'd2) begin
         errors++;
         $display("FAIL after_hold got=%0d/%0d exp=0/2", a_code, b_code);
      end
   endtask

`ifdef CUSTOM7_AUTO_RUN_EN
   task test_auto;
      rst = 1'b1;
      auto = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         checks++;
         if (a_code !== 3'(k / 10) || a_step !== (k % 10 == 0) || a_wrap !== 1'b0 || b_code !== 3'(k / 10)) begin
            errors++;
            $display("FAIL auto_run k=%0d got code=%0d step=%b exp code=%0d step=%b", k, a_code, a_step, k / 10, k % 10 == 0);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (a_code !== 3'd0) begin
         errors++;
         $display("FAIL auto_rst got=%0d exp=0", a_code);
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (k < 20 && (a_code !== 3'(k / 10) || a_step !== (k == 10))) begin
            errors++;
            $display("FAIL auto_after_rst k=%0d got code=%0d step=%b exp code=%0d step=%b", k, a_code, a_step, k / 10, k == 10);
         end
         if (k == 20 && (a_code !== 3'd0 || a_step !== 1'b1 || a_wrap !== 1'b0 || b_code !== 3'd0)) begin
            errors++;
            $display("FAIL auto_tick_vs_dn got code=%0d/%0d step=%b wrap=%b exp code=0/0 step=1 wrap=0", a_code, b_code, a_step, a_wrap);
         end
         if (k == 13) btn_dn = 1'b1;
      end
      btn_dn = 1'b0;
      auto = 1'b0;
      repeat (12) @(negedge clk);
   endtask
`endif

   task test_random;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         checks++;
         if ({a_code, a_step, a_wrap, b_code, b_step, b_wrap} !==
             {3'(m_code[0]), m_step[0], m_wrap[0], 3'(m_code[1]), m_step[1], m_wrap[1]}) begin
            errors++;
            $display("FAIL random cyc=%0d got=%0d/%b/%b %0d/%b/%b exp=%0d/%b/%b %0d/%b/%b", n,
                     a_code, a_step, a_wrap, b_code, b_step, b_wrap,
                     m_code[0], m_step[0], m_wrap[0], m_code[1], m_step[1], m_wrap[1]);
         end
         if ($urandom_range(5) == 0) btn_up = ~btn_up;
         if ($urandom_range(5) == 0) btn_dn = ~btn_dn;
         if ($urandom_range(39) == 0) hold = ~hold;
`ifdef CUSTOM7_AUTO_RUN_EN
         if ($urandom_range(49) == 0) auto = ~auto;
`endif
         rst = ($urandom_range(299) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_bounce();
      test_wrap();
      test_both_hold();
`ifdef CUSTOM7_AUTO_RUN_EN
      test_auto();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
